spi_memory_burst_reader: RTL and testbench

// Upstream sequencer for spi_memory_master: turns one {start_addr, length} request into a read transaction.

---
 rtl/spi_memory_burst_reader.sv | 174 +++++++++++++++++
 tb/tb_spi_memory_burst_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_memory_burst_reader.sv
// Sequences one {start_addr, length} read burst through spi_memory_master and
// streams the received bytes out on a valid/ready interface.
module spi_memory_burst_reader #(
  parameter int          ADDR_BYTES   = 3,
  parameter int          LEN_BITS     = 16,
  parameter logic [7:0]  READ_OPCODE  = 8'h0B,
  parameter logic [3:0]  DUMMY_CYCLES = 4'd8,
  parameter int          TIMEOUT_BITS = 12
) (
  input  logic                    main_clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*ADDR_BYTES-1:0] start_addr,
  input  logic [LEN_BITS-1:0]     length,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              mem_opcode,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [3:0]              mem_dummy_cycles,
  output logic [7:0]              mem_write_data,
  output logic                    mem_addr_flag,
  output logic                    mem_opcode_addr_trigger,
  output logic                    mem_data_trigger,
  output logic                    mem_finalize_trigger,
  input  logic                    mem_opcode_addr_completed,
  input  logic                    mem_data_ready,
  input  logic                    mem_data_completed,
  input  logic [7:0]              mem_read_data
);

  typedef enum logic [3:0] {
    S_RECOVER,
    S_IDLE,
    S_CMD_TRIG,
    S_CMD_WAIT,
    S_BYTE_TRIG,
    S_BYTE_ACK,
    S_BYTE_WAIT,
    S_OUT_HOLD,
    S_FIN,
    S_FIN_WAIT,
    S_DONE
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX      = '1;
  localparam logic [TIMEOUT_BITS-1:0] CNT_ONE     = TIMEOUT_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] CNT_TWO     = TIMEOUT_BITS'(2);
  localparam logic [TIMEOUT_BITS-1:0] RECOVER_END = TIMEOUT_BITS'(6);

  state_t                  state, state_next;
  logic [TIMEOUT_BITS-1:0] cnt;
  logic [LEN_BITS-1:0]     remaining;
  logic                    accept, byte_done, consume, timeout, wd_expired;

  assign mem_opcode       = READ_OPCODE;
  assign mem_dummy_cycles = DUMMY_CYCLES;
  assign mem_write_data   = 8'h00;
  assign mem_addr_flag    = 1'b1;

  assign wd_expired = (cnt == WD_MAX);

  // Triggers decode from registered state so they fall to 0 the moment reset asserts.
  // RECOVER keeps phase 0 low so the finalize edge is seen after reset releases.
  assign mem_opcode_addr_trigger = (state == S_CMD_TRIG);
  assign mem_data_trigger        = (state == S_BYTE_TRIG);
  assign mem_finalize_trigger    = (state == S_FIN) ||
                                   ((state == S_RECOVER) && (cnt == CNT_ONE || cnt == CNT_TWO));
  assign busy = (state != S_RECOVER) && (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RECOVER;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (cnt != WD_MAX)
        cnt <= cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    byte_done  = 1'b0;
    consume    = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_RECOVER:   if (cnt == RECOVER_END) state_next = S_IDLE;
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (length == '0) ? S_DONE : S_CMD_TRIG;
        end
      end
      S_CMD_TRIG:  if (cnt == CNT_ONE) state_next = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (mem_opcode_addr_completed) state_next = S_BYTE_TRIG;
        else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = S_FIN;
        end
      end
      S_BYTE_TRIG: if (cnt == CNT_ONE) state_next = S_BYTE_ACK;
      S_BYTE_ACK: begin
        if (!mem_data_ready) state_next = S_BYTE_WAIT;
        else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = S_FIN;
        end
      end
      S_BYTE_WAIT: begin
        if (mem_data_completed) begin
          byte_done  = 1'b1;
          state_next = S_OUT_HOLD;
        end else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = S_FIN;
        end
      end
      // No watchdog here: the consumer may stall indefinitely with CS held low.
      S_OUT_HOLD: begin
        if (out_valid && out_ready) begin
          consume    = 1'b1;
          state_next = (remaining == '0) ? S_FIN : S_BYTE_TRIG;
        end
      end
      S_FIN:       if (cnt == CNT_ONE) state_next = S_FIN_WAIT;
      S_FIN_WAIT: begin
        if (!mem_opcode_addr_completed) state_next = S_DONE;
        else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_RECOVER;
    endcase
  end

  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      remaining <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= start_addr;
        remaining <= length;
        error     <= 1'b0;
      end
      if (byte_done) begin
        out_data  <= mem_read_data;
        out_valid <= 1'b1;
        remaining <= remaining - LEN_BITS'(1);
      end
      if (consume)
        out_valid <= 1'b0;
      if (timeout) begin
        error     <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_memory_burst_reader.sv
// Bench for spi_memory_burst_reader: behavioural SPI master model, per-cycle
// monitor of trigger timing and byte stream, and directed request scenarios.
module tb_spi_memory_burst_reader;

  localparam int CMD_LAT = 10;
  localparam int DAT_LAT = 6;

  logic        main_clock = 1'b0;
  logic        reset_n    = 1'b1;
  logic        start      = 1'b0;
  logic [23:0] start_addr = '0;
  logic [15:0] length     = '0;
  logic        out_ready  = 1'b1;
  logic        busy, done, error, out_valid;
  logic [7:0]  out_data, mem_opcode, mem_write_data;
  logic [23:0] mem_addr;
  logic [3:0]  mem_dummy_cycles;
  logic        mem_addr_flag;
  logic        oa_trig, d_trig, f_trig;

  // master model state (no reset, like the real master)
  logic        cmd_done = 1'b0, d_ready = 1'b0, d_done = 1'b0;
  logic [7:0]  rd_data  = 8'h00;
  logic        oa_prev = 1'b0, d_prev = 1'b0, f_prev = 1'b0;
  int          c_cnt = 0, d_cnt = 0, m_idx = 0;
  int          oa_edges = 0, d_edges = 0, f_edges = 0;
  logic [7:0]  cap_op = 8'h00;
  logic [23:0] cap_addr = '0;
  logic [7:0]  bytes [8];
  logic        stall_data = 1'b0;

  int tests = 0, fails = 0;
  int rx_idx = 0, done_cnt = 0;

  always #5 main_clock = ~main_clock;

  spi_memory_burst_reader dut (
    .main_clock                (main_clock),
    .reset_n                   (reset_n),
    .start                     (start),
    .start_addr                (start_addr),
    .length                    (length),
    .busy                      (busy),
    .done                      (done),
    .error                     (error),
    .out_data                  (out_data),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready),
    .mem_opcode                (mem_opcode),
    .mem_addr                  (mem_addr),
    .mem_dummy_cycles          (mem_dummy_cycles),
    .mem_write_data            (mem_write_data),
    .mem_addr_flag             (mem_addr_flag),
    .mem_opcode_addr_trigger   (oa_trig),
    .mem_data_trigger          (d_trig),
    .mem_finalize_trigger      (f_trig),
    .mem_opcode_addr_completed (cmd_done),
    .mem_data_ready            (d_ready),
    .mem_data_completed        (d_done),
    .mem_read_data             (rd_data)
  );

  // Master model: registered edge detection, fixed latencies, bytes from the table.
  always @(posedge main_clock) begin
    oa_prev <= oa_trig;
    d_prev  <= d_trig;
    f_prev  <= f_trig;
    if (f_trig && !f_prev) begin
      f_edges  <= f_edges + 1;
      cmd_done <= 1'b0;
      d_ready  <= 1'b0;
      d_done   <= 1'b0;
      c_cnt    <= 0;
      d_cnt    <= 0;
    end else begin
      if (oa_trig && !oa_prev) begin
        oa_edges <= oa_edges + 1;
        cap_op   <= mem_opcode;
        cap_addr <= mem_addr;
        m_idx    <= 0;
        c_cnt    <= CMD_LAT;
      end else if (c_cnt != 0) begin
        c_cnt <= c_cnt - 1;
        if (c_cnt == 1) begin
          cmd_done <= 1'b1;
          d_ready  <= 1'b1;
        end
      end
      if (d_trig && !d_prev) begin
        d_edges <= d_edges + 1;
        d_ready <= 1'b0;
        d_done  <= 1'b0;
        if (!stall_data) d_cnt <= DAT_LAT;
      end else if (d_cnt != 0) begin
        d_cnt <= d_cnt - 1;
        if (d_cnt == 1) begin
          d_done  <= 1'b1;
          d_ready <= 1'b1;
          rd_data <= bytes[m_idx & 7];
          m_idx   <= m_idx + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: trigger shape, held stream, byte order, constant ties.
  task automatic monitor();
    logic [2:0] trg;
    int         hi [3];
    int         lo [3];
    logic       pv, pr;
    logic [7:0] pd;
    hi = '{0, 0, 0};
    lo = '{9, 9, 9};
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge main_clock);
      if (!reset_n) begin
        hi = '{0, 0, 0};
        lo = '{9, 9, 9};
        pv = 1'b0;
      end else begin
        trg = {f_trig, d_trig, oa_trig};
        for (int k = 0; k < 3; k++) begin
          if (trg[k]) begin
            if (hi[k] == 0) begin
              chk("trig_low_gap", 32'(lo[k] >= 2), 1);
              if (k == 0) rx_idx = 0;
            end
            hi[k]++;
            lo[k] = 0;
          end else begin
            if (hi[k] != 0) chk("trig_high_width", hi[k], 2);
            hi[k] = 0;
            lo[k]++;
          end
        end
        if (pv && !pr) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_data", 32'(out_data), 32'(pd));
        end
        if (out_valid && out_ready) begin
          chk("stream_byte", 32'(out_data), 32'(bytes[rx_idx & 7]));
          rx_idx++;
        end
        chk("tie_opcode", 32'(mem_opcode), 32'h0B);
        chk("tie_dummy", 32'(mem_dummy_cycles), 32'd8);
        chk("tie_wdata_flag", 32'({mem_write_data, mem_addr_flag}), 32'h001);
        if (done) done_cnt++;
        pv = out_valid; pr = out_ready; pd = out_data;
      end
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [15:0] n);
    @(posedge main_clock); #1;
    start = 1'b1; start_addr = a; length = n;
    @(posedge main_clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < budget && !ok) begin
      @(negedge main_clock);
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge main_clock);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc, f0, o0, d0, dc0;
    bit ok;
    for (int i = 0; i < 8; i++) bytes[i] = 8'h00;
    fork
      monitor();
    join_none

    // Reset: outputs clear while held low, then one recovery finalize edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_outputs", 32'({busy, done, error, out_valid, oa_trig, d_trig, f_trig}), 0);
    chk("rst_data_addr", 32'({out_data, mem_addr}), 0);
    repeat (3) @(posedge main_clock);
    #1 reset_n = 1'b1;
    idle(20);
    chk("rst_finalize_edges", f_edges, 1);
    chk("rst_no_opcode_trig", oa_edges, 0);
    chk("rst_idle_busy_valid", 32'({busy, out_valid}), 0);

    // Basic 3-byte read.
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
    out_ready = 1'b1;
    f0 = f_edges; o0 = oa_edges; d0 = d_edges;
    start_req(24'h012345, 16'd3);
    @(negedge main_clock);
    chk("t1_busy", 32'(busy), 1);
    wait_done(500, cyc, ok);
    chk("t1_done_seen", 32'(ok), 1);
    chk("t1_error", 32'(error), 0);
    chk("t1_opcode_sent", 32'(cap_op), 32'h0B);
    chk("t1_addr_sent", 32'(cap_addr), 32'h012345);
    chk("t1_bytes_rx", rx_idx, 3);
    chk("t1_edges", 32'({8'(oa_edges - o0), 8'(d_edges - d0), 8'(f_edges - f0)}), 32'h010301);
    @(negedge main_clock);
    chk("t1_after_done", 32'({done, busy}), 0);
    idle(5);

    // Zero length: immediate done, no SPI activity.
    f0 = f_edges; o0 = oa_edges; d0 = d_edges;
    start_req(24'h000010, 16'd0);
    wait_done(3, cyc, ok);
    chk("t2_done_seen", 32'(ok), 1);
    chk("t2_latency", 32'(cyc <= 2), 1);
    @(negedge main_clock);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_no_edges", (oa_edges - o0) + (d_edges - d0) + (f_edges - f0), 0);
    idle(5);

    // Backpressure: consumer stalls 50 cycles on the first byte.
    bytes[0] = 8'hAA; bytes[1] = 8'hBB;
    out_ready = 1'b0;
    d0 = d_edges;
    start_req(24'h000200, 16'd2);
    cyc = 0;
    while (cyc < 200 && !out_valid) begin
      @(negedge main_clock);
      cyc++;
    end
    chk("t3_first_valid", 32'(out_valid), 1);
    idle(50);
    chk("t3_held_byte", 32'({out_valid, out_data}), 32'h1AA);
    chk("t3_no_second_trig", d_edges - d0, 1);
    @(posedge main_clock); #1 out_ready = 1'b1;
    wait_done(300, cyc, ok);
    chk("t3_done_seen", 32'(ok), 1);
    chk("t3_bytes_rx", rx_idx, 2);
    chk("t3_data_edges", d_edges - d0, 2);
    idle(5);

    // Watchdog: master never completes the data byte.
    stall_data = 1'b1;
    f0 = f_edges;
    start_req(24'h000300, 16'd2);
    wait_done(6000, cyc, ok);
    chk("t4_done_seen", 32'(ok), 1);
    chk("t4_error_set", 32'(error), 1);
    chk("t4_waited_out", 32'(cyc > 4095), 1);
    chk("t4_finalize", f_edges - f0, 1);
    chk("t4_no_bytes", rx_idx, 0);
    stall_data = 1'b0;
    idle(3);
    chk("t4_error_sticky", 32'(error), 1);
    bytes[0] = 8'h5A;
    start_req(24'h000400, 16'd1);
    @(negedge main_clock);
    chk("t4_error_cleared", 32'(error), 0);
    wait_done(300, cyc, ok);
    chk("t4_recovered", 32'({ok, error}), 32'h2);
    chk("t4_recovered_rx", rx_idx, 1);
    idle(5);

    // Async reset during byte 2 of a 4-byte read.
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    start_req(24'h000500, 16'd4);
    cyc = 0;
    while (cyc < 300 && rx_idx < 1) begin
      @(negedge main_clock);
      cyc++;
    end
    chk("t5_first_byte", rx_idx, 1);
    idle(3);
    dc0 = done_cnt; f0 = f_edges;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_outputs", 32'({busy, done, error, out_valid, oa_trig, d_trig, f_trig}), 0);
    chk("t5_rst_data_addr", 32'({out_data, mem_addr}), 0);
    repeat (2) @(posedge main_clock);
    #1 reset_n = 1'b1;
    idle(20);
    chk("t5_recover_finalize", f_edges - f0, 1);
    chk("t5_no_done", done_cnt - dc0, 0);
    chk("t5_idle", 32'(busy), 0);
    bytes[0] = 8'h77; bytes[1] = 8'h88;
    start_req(24'h000600, 16'd2);
    wait_done(500, cyc, ok);
    chk("t5_done_seen", 32'(ok), 1);
    chk("t5_addr_sent", 32'(cap_addr), 32'h000600);
    chk("t5_bytes_rx", rx_idx, 2);
    chk("t5_error", 32'(error), 0);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
